// File: rtl/nn_pkg.sv
// Shared element definitions for the network layer blocks and the argmax stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nn_pkg;

   // Activation width shared by every layer and the argmax stage.
   localparam int T = 16;

   // One signed activation value.
   typedef logic signed [T-1:0] elem_t;

endpackage : nn_pkg

// File: rtl/argmax_cmp.sv
// Picks between a running (value, index) pair and an incoming pair: incoming wins when first or strictly greater.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when the selected pair is captured.
module argmax_cmp
   import nn_pkg::*;
#(
   parameter int IW = 3
) (
   input  logic                i_first,
   input  logic signed [T-1:0] i_run_val,
   input  logic [IW-1:0]       i_run_idx,
   input  logic signed [T-1:0] i_new_val,
   input  logic [IW-1:0]       i_new_idx,
   output logic signed [T-1:0] o_val,
   output logic [IW-1:0]       o_idx
);

   logic w_take_new;

   // Strict signed compare so an equal later element never displaces an earlier one.
   always_comb begin
      w_take_new = i_first || (i_new_val > i_run_val);
      o_val      = w_take_new ? i_new_val : i_run_val;
      o_idx      = w_take_new ? i_new_idx : i_run_idx;
   end

endmodule : argmax_cmp

// File: rtl/argmax_8_16.sv
// Streaming argmax: folds N signed elements per vector and emits (index, value) of the maximum.
// Latency: result valid on the edge that accepts element N-1; one element per cycle sustained.
// Backpressure: stalls only the last element of a vector while a previous result is still held.
module argmax_8_16
   import nn_pkg::*;
#(
   parameter int  N  = 8,
   localparam int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [T-1:0]  data_in,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [IW-1:0] data_out,
   output logic [T-1:0]  max_out
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   // Accumulator for the vector currently streaming in.
   logic [IW-1:0] r_cnt;
   elem_t         r_run_max;
   logic [IW-1:0] r_run_idx;

   // Result register presented downstream.
   logic          r_m_valid;
   logic [IW-1:0] r_data_out;
   elem_t         r_max_out;

   logic          w_at_last;
   logic          w_first;
   logic          w_s_ready;
   logic          w_accept;
   logic          w_last_accept;
   logic          w_result_take;
   elem_t         w_sel_val;
   logic [IW-1:0] w_sel_idx;

   // Handshake decode; s_ready looks only at state and m_ready, never at s_valid.
   always_comb begin
      w_at_last     = (r_cnt == LAST_IDX);
      w_first       = (r_cnt == '0);
      w_s_ready     = !(w_at_last && r_m_valid && !m_ready);
      w_accept      = s_valid && w_s_ready;
      w_last_accept = w_accept && w_at_last;
      w_result_take = r_m_valid && m_ready;
   end

   // Single selector: its output is both the next running state and the
   // final result, so the last element is already folded in when the result loads.
   argmax_cmp #(
      .IW (IW)
   ) u_cmp (
      .i_first   (w_first),
      .i_run_val (r_run_max),
      .i_run_idx (r_run_idx),
      .i_new_val (data_in),
      .i_new_idx (r_cnt),
      .o_val     (w_sel_val),
      .o_idx     (w_sel_idx)
   );

   // Running max/index and element position; gaps in s_valid leave them untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_run_max <= '0;
         r_run_idx <= '0;
      end else if (w_accept) begin
         r_run_max <= w_sel_val;
         r_run_idx <= w_sel_idx;
         r_cnt     <= w_at_last ? '0 : r_cnt + 1'b1;
      end
   end

   // Result register: a new result overrides a same-cycle take, otherwise a take clears valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_m_valid  <= 1'b0;
         r_data_out <= '0;
         r_max_out  <= '0;
      end else if (w_last_accept) begin
         r_m_valid  <= 1'b1;
         r_data_out <= w_sel_idx;
         r_max_out  <= w_sel_val;
      end else if (w_result_take) begin
         r_m_valid  <= 1'b0;
      end
   end

   assign s_ready  = w_s_ready;
   assign m_valid  = r_m_valid;
   assign data_out = r_data_out;
   assign max_out  = r_max_out;

endmodule : argmax_8_16

// File: tb/tb_argmax_8_16.sv
// Bench for argmax_8_16: directed vectors with literal expectations plus randomized traffic.
// A cycle model (vector buffer + software argmax) is compared against the DUT every cycle.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_argmax_8_16;

   localparam int N = 8;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        s_valid  = 1'b0;
   logic        s_ready;
   logic [15:0] data_in  = '0;
   logic        m_valid;
   logic        m_ready  = 1'b0;
   logic [2:0]  data_out;
   logic [15:0] max_out;

   int checks   = 0;
   int failures = 0;
   int res_cnt  = 0;
   bit rand_mr  = 1'b0;

   // Behavioural model state.
   int                 mcnt = 0;
   bit                 mv   = 1'b0;
   logic [2:0]         midx = '0;
   logic signed [15:0] mmax = '0;
   logic signed [15:0] mbuf [N];

   argmax_8_16 dut (
      .clk      (clk),
      .reset    (reset),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .data_in  (data_in),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .data_out (data_out),
      .max_out  (max_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Per-cycle model and compare.
   always @(negedge clk) begin
      bit exp_rdy;
      bit acc;
      bit take;
      int best;
      if (reset) begin
         mcnt = 0;
         mv   = 1'b0;
         midx = '0;
         mmax = '0;
         chk("rst_m_valid",  {15'd0, m_valid}, 16'd0);
         chk("rst_data_out", {13'd0, data_out}, 16'd0);
         chk("rst_max_out",  max_out, 16'd0);
         chk("rst_s_ready",  {15'd0, s_ready}, 16'd1);
      end else begin
         exp_rdy = !(mcnt == N-1 && mv && !m_ready);
         chk("cyc_s_ready",  {15'd0, s_ready}, {15'd0, exp_rdy});
         chk("cyc_m_valid",  {15'd0, m_valid}, {15'd0, mv});
         chk("cyc_data_out", {13'd0, data_out}, {13'd0, midx});
         chk("cyc_max_out",  max_out, mmax);
         acc  = s_valid && exp_rdy;
         take = mv && m_ready;
         if (take) res_cnt++;
         if (acc) mbuf[mcnt] = $signed(data_in);
         if (acc && mcnt == N-1) begin
            best = 0;
            for (int i = 1; i < N; i++)
               if (mbuf[i] > mbuf[best]) best = i;
            mv   = 1'b1;
            midx = 3'(best);
            mmax = mbuf[best];
            mcnt = 0;
         end else begin
            if (acc) mcnt++;
            if (take) mv = 1'b0;
         end
      end
   end

   // Random m_ready when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_mr) m_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic push(input logic [15:0] v, input bit gaps);
      bit acc;
      int guard;
      if (gaps) begin
         while ($urandom_range(0, 1) == 1) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      s_valid = 1'b1;
      data_in = v;
      guard   = 0;
      acc     = 1'b0;
      while (!acc && guard < 1000) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      s_valid = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL push_timeout actual=stalled expected=accept value=%0h", v);
      end
   endtask

   task automatic send_vec(input logic [15:0] v [N], input bit gaps);
      for (int i = 0; i < N; i++) push(v[i], gaps);
   endtask

   task automatic expect_result(input string nm, input logic [2:0] idx, input logic [15:0] mx);
      @(negedge clk);
      chk({nm, "_valid"}, {15'd0, m_valid}, 16'd1);
      chk({nm, "_idx"},   {13'd0, data_out}, {13'd0, idx});
      chk({nm, "_max"},   max_out, mx);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_idle(input string nm);
      @(negedge clk);
      chk(nm, {15'd0, m_valid}, 16'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] vec [N];
      logic [15:0] d;
      int g;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_s_ready", {15'd0, s_ready}, 16'd1);
      chk("post_reset_m_valid", {15'd0, m_valid}, 16'd0);
      @(posedge clk);
      #1;
      m_ready = 1'b1;

      // Basic: tie at index 4 must not displace index 2; result valid for one cycle.
      vec = '{16'd3, 16'hFFFF, 16'd7, 16'd2, 16'd7, 16'd0, 16'hFFFB, 16'd1};
      send_vec(vec, 1'b0);
      expect_result("basic", 3'd2, 16'd7);
      expect_idle("basic_pulse");

      // Signed extremes.
      vec = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF};
      send_vec(vec, 1'b0);
      expect_result("ext_pos", 3'd7, 16'h7FFF);
      vec = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
      send_vec(vec, 1'b0);
      expect_result("ext_neg", 3'd0, 16'h8000);
      expect_idle("ext_pulse");

      // Backpressure: result A held while B's first seven elements stream in.
      m_ready = 1'b0;
      vec = '{16'd5, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
      send_vec(vec, 1'b0);
      vec = '{16'd0, 16'd0, 16'd0, 16'hFFFD, 16'd20, 16'd0, 16'd0, 16'd4};
      for (int i = 0; i < N-1; i++) push(vec[i], 1'b0);
      s_valid = 1'b1;
      data_in = vec[N-1];
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_s_ready_low", {15'd0, s_ready}, 16'd0);
         chk("bp_hold_valid",  {15'd0, m_valid}, 16'd1);
         chk("bp_hold_idx",    {13'd0, data_out}, 16'd0);
         chk("bp_hold_max",    max_out, 16'd5);
         @(posedge clk);
         #1;
      end
      m_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_s_ready", {15'd0, s_ready}, 16'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      expect_result("bp_B", 3'd4, 16'd20);
      expect_idle("bp_pulse");

      // Reset mid-vector with a pending result: both discarded.
      m_ready = 1'b0;
      vec = '{16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'd99, 16'd1, 16'd2};
      send_vec(vec, 1'b0);
      for (int i = 0; i < 4; i++) push(16'd100, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_m_valid", {15'd0, m_valid}, 16'd0);
      chk("midrst_s_ready", {15'd0, s_ready}, 16'd1);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      m_ready = 1'b1;
      expect_idle("midrst_no_stale");
      vec = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd9, 16'd0, 16'd0};
      send_vec(vec, 1'b0);
      expect_result("midrst", 3'd5, 16'd9);
      expect_idle("midrst_pulse");

      // Randomized traffic: 1250 vectors with random gaps and random m_ready.
      res_cnt = 0;
      rand_mr = 1'b1;
      for (int v = 0; v < 1250; v++) begin
         for (int e = 0; e < N; e++) begin
            d = 16'($urandom);
            case ($urandom_range(0, 7))
               0, 1:    d = {14'd0, 2'($urandom)};
               2:       d = 16'h8000;
               3:       d = 16'h7FFF;
               default: ;
            endcase
            push(d, 1'b1);
         end
      end
      s_valid = 1'b0;
      g = 0;
      while (m_valid && g < 200) begin
         @(posedge clk);
         #1;
         g++;
      end
      rand_mr = 1'b0;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rand_drained", {15'd0, m_valid}, 16'd0);
      chk("rand_result_count", 16'(res_cnt), 16'd1250);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_argmax_8_16
